// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default widths for the memory port arbiter
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data-memory, memory and stall signals of the arbiter
interface mem_port_arbiter_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_flush_i;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_done_o;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_gnt_o, dm_done_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_gnt_o, dm_done_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating count of conflicts lost by fetch
module starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_limit_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign at_limit_o = (cnt_q == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data stages
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);
    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drop_q;
    logic              if_rvalid_q, dm_done_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    logic if_win, dm_win, wr_done, rd_done;
    logic at_limit, starve_inc, flush_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if_win  = 1'b0;
        dm_win  = 1'b0;
        wr_done = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins conflicts until fetch has lost STARVE_LIMIT of them in a row.
                if_win = bus.if_req_i & (~bus.dm_req_i | at_limit);
                dm_win = bus.dm_req_i & ~if_win;
                if (if_win | dm_win) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready_i) begin
                    if (we_q) begin
                        state_d = IDLE;
                        wr_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    state_d = IDLE;
                    rd_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign starve_inc = (state_q == IDLE) & bus.if_req_i & bus.dm_req_i & ~if_win;
    assign flush_hit  = (state_q != IDLE) & (owner_q == OWN_IF) & bus.if_flush_i;

    starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (starve_inc),
        .clr_i      (if_win),
        .at_limit_o (at_limit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            drop_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_done_q   <= 1'b0;
            drop_q      <= (state_d != IDLE) & (drop_q | flush_hit);
            if (if_win | dm_win) begin
                owner_q <= if_win ? OWN_IF : OWN_DM;
                we_q    <= dm_win & bus.dm_we_i;
                addr_q  <= if_win ? bus.if_addr_i : bus.dm_addr_i;
                wdata_q <= dm_win ? bus.dm_wdata_i : '0;
            end
            if (wr_done) begin
                dm_done_q <= 1'b1;
            end
            if (rd_done) begin
                if (owner_q == OWN_DM) begin
                    dm_done_q  <= 1'b1;
                    dm_rdata_q <= bus.mem_rdata_i;
                end else if (!(drop_q | bus.if_flush_i)) begin
                    // A flush on the same cycle as the data return still discards it.
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= bus.mem_rdata_i;
                end
            end
        end
    end

    // Grants and stall are combinational, so hold them low while reset is asserted.
    assign bus.if_gnt_o    = if_win & ~rst_i;
    assign bus.dm_gnt_o    = dm_win & ~rst_i;
    assign bus.if_rvalid_o = if_rvalid_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_done_o   = dm_done_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.mem_req_o   = (state_q == ISSUE);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.stall_o     = ~rst_i & ((bus.if_req_i & ~if_win) | (bus.dm_req_i & ~dm_win)
                                       | (state_q != IDLE));

endmodule
